// File: rtl/goto_rep_if.sv
// Transaction bus between the goto-repetition generator and its consumers.
interface goto_rep_if;
    logic        go;
    logic [1:0]  err_mode;
    logic        start;
    logic        event_signal;
    logic        done;
    logic        busy;
    logic [15:0] txn_count;

    modport master (
        input  go,
        input  err_mode,
        output start,
        output event_signal,
        output done,
        output busy,
        output txn_count
    );

    modport slave (
        output go,
        output err_mode,
        input  start,
        input  event_signal,
        input  done,
        input  busy,
        input  txn_count
    );
endinterface

// File: rtl/goto_rep_seq_gen.sv
// Generates start ##1 event[->N] ##D done traces, with optional injected
// violations, using an LFSR to randomise the idle gaps before each event.
module goto_rep_seq_gen #(
    parameter int          N_EVENTS   = 3,
    parameter int          DONE_DELAY = 2,
    parameter int          MAX_GAP    = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    goto_rep_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_EVENT = 3'd3;
    localparam logic [2:0] S_DELAY = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] SEED =
        (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [3:0]  GAP_MAX   = 4'(MAX_GAP);
    localparam logic [15:0] N_EV      = 16'(N_EVENTS);
    localparam logic [15:0] D_LEN     = 16'(DONE_DELAY);

    logic [2:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [3:0]  gap_q, gap_d;
    logic [15:0] evt_q, evt_d;
    logic [15:0] dly_q, dly_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        start_q, start_d;
    logic        event_q, event_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] target;
    logic [15:0] dlen;
    logic [15:0] evt_inc;
    logic [15:0] lfsr_step;
    logic [3:0]  gap_new;
    logic        load_gap;
    logic        enter_delay;

    always_comb begin
        target = N_EV;
        if (mode_q == 2'd1) target = N_EV + 16'd1;
        if (mode_q == 2'd2) target = N_EV - 16'd1;
    end

    assign dlen    = (mode_q == 2'd3) ? D_LEN + 16'd1 : D_LEN;
    assign evt_inc = evt_q + 16'd1;
    assign gap_new = (lfsr_q[3:0] > GAP_MAX) ? GAP_MAX : lfsr_q[3:0];

    // Galois form: shift right, fold the mask in when a 1 drops out.
    assign lfsr_step = {1'b0, lfsr_q[15:1]}
                     ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        gap_d       = gap_q;
        evt_d       = evt_q;
        dly_d       = dly_q;
        lfsr_d      = lfsr_q;
        load_gap    = 1'b0;
        enter_delay = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_START;
                    mode_d  = bus.err_mode;
                    evt_d   = 16'd0;
                end
            end
            S_START: begin
                if (target == 16'd0) enter_delay = 1'b1;
                else                 load_gap    = 1'b1;
            end
            S_GAP: begin
                if (gap_q <= 4'd1) state_d = S_EVENT;
                else               gap_d   = gap_q - 4'd1;
            end
            S_EVENT: begin
                evt_d = evt_inc;
                if (evt_inc < target) load_gap    = 1'b1;
                else                  enter_delay = 1'b1;
            end
            S_DELAY: begin
                if (dly_q <= 16'd1) state_d = S_DONE;
                else                dly_d   = dly_q - 16'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A zero gap means the event lands in the very next cycle.
        if (load_gap) begin
            lfsr_d  = lfsr_step;
            gap_d   = gap_new;
            state_d = (gap_new == 4'd0) ? S_EVENT : S_GAP;
        end

        if (enter_delay) begin
            dly_d   = dlen - 16'd1;
            state_d = (dlen <= 16'd1) ? S_DONE : S_DELAY;
        end
    end

    // Outputs are decoded from the next state so they are registered.
    always_comb begin
        start_d = (state_d == S_START);
        event_d = (state_d == S_EVENT);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        cnt_d   = (state_d == S_DONE) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            gap_q   <= 4'd0;
            evt_q   <= 16'd0;
            dly_q   <= 16'd0;
            lfsr_q  <= SEED;
            start_q <= 1'b0;
            event_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            gap_q   <= gap_d;
            evt_q   <= evt_d;
            dly_q   <= dly_d;
            lfsr_q  <= lfsr_d;
            start_q <= start_d;
            event_q <= event_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.start        = start_q;
    assign bus.event_signal = event_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.txn_count    = cnt_q;

endmodule

// File: tb/tb_goto_rep_seq_gen.sv
// Bench for goto_rep_seq_gen: three configurations, expected pulses queued
// when go is driven and popped as the DUT emits start/event/done.
module tb_goto_rep_seq_gen;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        int          n;
        int          dly;
        logic [15:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [15:0] m1;

    goto_rep_if i0();
    goto_rep_if i1();
    goto_rep_if i2();

    goto_rep_seq_gen #(.MAX_GAP(0)) u0 (
        .clk(clk), .rst(rst), .bus(i0)
    );
    goto_rep_seq_gen #(.MAX_GAP(15)) u1 (
        .clk(clk), .rst(rst), .bus(i1)
    );
    goto_rep_seq_gen #(.N_EVENTS(1), .MAX_GAP(0)) u2 (
        .clk(clk), .rst(rst), .bus(i2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] r;
        r = x >> 1;
        if (x[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int kind, input int c);
        exp_t it;
        it.kind = kind;
        it.cyc  = c;
        case (d)
            0:       q0.push_back(it);
            1:       q1.push_back(it);
            default: q2.push_back(it);
        endcase
    endtask

    task automatic set_go(input int d, input logic v, input logic [1:0] m);
        case (d)
            0:       begin i0.go = v; i0.err_mode = m; end
            1:       begin i1.go = v; i1.err_mode = m; end
            default: begin i2.go = v; i2.err_mode = m; end
        endcase
    endtask

    task automatic status(input int d, output logic b, output logic [15:0] c);
        case (d)
            0:       begin b = i0.busy; c = i0.txn_count; end
            1:       begin b = i1.busy; c = i1.txn_count; end
            default: begin b = i2.busy; c = i2.txn_count; end
        endcase
    endtask

    task automatic mon(input int d, input logic s, input logic e,
                       input logic dn, input logic b);
        exp_t it;
        bit   have;
        int   k;
        if (!(s | e | dn)) return;
        chk("exclusive", 32'(int'(s) + int'(e) + int'(dn)), 32'd1);
        k    = s ? 0 : (e ? 1 : 2);
        have = 1'b0;
        case (d)
            0: if (q0.size() > 0) begin it = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin it = q1.pop_front(); have = 1'b1; end
            default:
               if (q2.size() > 0) begin it = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_pulse: dut%0d kind %0d at cycle %0d, none required",
                     d, k, cyc);
        end else begin
            chk($sformatf("pulse_kind_dut%0d", d), 32'(k), 32'(it.kind));
            chk($sformatf("pulse_cycle_dut%0d", d), 32'(cyc), 32'(it.cyc));
            chk("busy_on_pulse", 32'(b), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        mon(0, i0.start, i0.event_signal, i0.done, i0.busy);
        mon(1, i1.start, i1.event_signal, i1.done, i1.busy);
        mon(2, i2.start, i2.event_signal, i2.done, i2.busy);
    end

    // Zero-gap transaction: events back to back after start.
    task automatic txn(input int d, input logic [1:0] m, input int n,
                       input int dl, input logic [15:0] cnt);
        int          g;
        int          dc;
        logic        b;
        logic [15:0] c;
        @(negedge clk);
        g = cyc;
        set_go(d, 1'b1, m);
        push(d, 0, g + 1);
        for (int k = 0; k < n; k++) push(d, 1, g + 2 + k);
        dc = g + 1 + n + dl;
        push(d, 2, dc);
        @(negedge clk);
        set_go(d, 1'b0, 2'd0);
        while (cyc < dc + 1) @(negedge clk);
        status(d, b, c);
        chk("busy_after_done", 32'(b), 32'd0);
        chk("txn_count", 32'(c), 32'(cnt));
    endtask

    // go held high for cnt back-to-back transactions on the random-gap DUT.
    task automatic burst1(input int cnt, input logic [15:0] exp_cnt);
        int s;
        int t;
        int last;
        @(negedge clk);
        s = cyc + 1;
        last = s;
        i1.go = 1'b1;
        i1.err_mode = 2'd0;
        for (int i = 0; i < cnt; i++) begin
            push(1, 0, s);
            t = s;
            for (int k = 0; k < 3; k++) begin
                t = t + 1 + int'(m1[3:0]);
                m1 = lfsr_next(m1);
                push(1, 1, t);
            end
            push(1, 2, t + 2);
            last = t + 2;
            s = t + 4;
        end
        while (cyc < last) @(negedge clk);
        i1.go = 1'b0;
        @(negedge clk);
        chk("burst_busy_idle", 32'(i1.busy), 32'd0);
        chk("burst_txn_count", 32'(i1.txn_count), 32'(exp_cnt));
        repeat (3) @(negedge clk);
    endtask

    vec_t vecs[5];
    int   g;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m1     = 16'hACE1;
        vecs[0] = '{mode: 2'd0, n: 3, dly: 2, cnt: 16'd1};
        vecs[1] = '{mode: 2'd1, n: 4, dly: 2, cnt: 16'd2};
        vecs[2] = '{mode: 2'd2, n: 2, dly: 2, cnt: 16'd3};
        vecs[3] = '{mode: 2'd3, n: 3, dly: 3, cnt: 16'd4};
        vecs[4] = '{mode: 2'd0, n: 3, dly: 2, cnt: 16'd5};

        set_go(0, 1'b0, 2'd0);
        set_go(1, 1'b0, 2'd0);
        set_go(2, 1'b0, 2'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dut0", 32'({i0.start, i0.event_signal, i0.done,
                               i0.busy, i0.txn_count}), 32'd0);
        chk("reset_dut1", 32'({i1.start, i1.event_signal, i1.done,
                               i1.busy, i1.txn_count}), 32'd0);
        chk("reset_dut2", 32'({i2.start, i2.event_signal, i2.done,
                               i2.busy, i2.txn_count}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++)
            txn(0, vecs[i].mode, vecs[i].n, vecs[i].dly, vecs[i].cnt);

        // go while busy and in the DONE cycle must be ignored.
        @(negedge clk);
        g = cyc;
        i0.go = 1'b1;
        push(0, 0, g + 1);
        for (int k = 0; k < 3; k++) push(0, 1, g + 2 + k);
        push(0, 2, g + 6);
        @(negedge clk);
        i0.go = 1'b0;
        @(negedge clk);
        i0.go = 1'b1;
        repeat (2) @(negedge clk);
        i0.go = 1'b0;
        while (cyc < g + 6) @(negedge clk);
        chk("done_cycle_busy", 32'(i0.busy), 32'd1);
        i0.go = 1'b1;
        @(negedge clk);
        i0.go = 1'b0;
        repeat (4) @(negedge clk);
        chk("ignored_go_count", 32'(i0.txn_count), 32'd6);
        chk("ignored_go_queue", 32'(q0.size()), 32'd0);

        // Reset mid-transaction aborts it.
        @(negedge clk);
        g = cyc;
        i0.go = 1'b1;
        push(0, 0, g + 1);
        push(0, 1, g + 2);
        push(0, 1, g + 3);
        @(negedge clk);
        i0.go = 1'b0;
        while (cyc < g + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 32'({i0.start, i0.event_signal, i0.done,
                                  i0.busy, i0.txn_count}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 32'(q0.size()), 32'd0);
        txn(0, 2'd0, 3, 2, 16'd1);

        burst1(50, 16'd50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m1 = 16'hACE1;
        burst1(2, 16'd2);

        txn(2, 2'd2, 0, 2, 16'd1);
        txn(2, 2'd1, 2, 2, 16'd2);
        txn(2, 2'd0, 1, 2, 16'd3);
        txn(2, 2'd3, 1, 3, 16'd4);

        repeat (5) @(negedge clk);
        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);
        chk("final_q2_empty", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
